// File: rtl/avalon_pio_gen.sv
// Parametrised Avalon-MM PIO: output register with set/clear aliases, direction register,
// synchronised input port with sticky edge capture and a maskable level interrupt.
module avalon_pio_gen #(
   parameter int unsigned WIDTH       = 8,
   parameter logic [31:0] RESET_OUT   = '0,
   parameter logic [31:0] RESET_DIR   = '0,
   parameter int unsigned EDGE_TYPE   = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe_port,
   output logic             irq
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_DIR      = 3'd1;
   localparam logic [2:0] ADDR_MASK     = 3'd2;
   localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic             unused_wd;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] edge_det;

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] rd_val;

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   // Synchroniser chain plus one extra register holding the previous synchronised sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_in;
      end
   end

   assign sync_in = sync_q[SYNC_STAGES-1];

   always_comb begin
      case (EDGE_TYPE)
         0:       edge_det = sync_in & ~prev_q;
         1:       edge_det = ~sync_in & prev_q;
         default: edge_det = sync_in ^ prev_q;
      endcase
   end

   always_comb begin
      out_d  = out_q;
      dir_d  = dir_q;
      mask_d = mask_q;
      cap_d  = cap_q;
      if (wr) begin
         case (address)
            ADDR_DATA:     out_d  = wd;
            ADDR_DIR:      dir_d  = wd;
            ADDR_MASK:     mask_d = wd;
            ADDR_CAPTURE:  cap_d  = cap_q & ~wd;
            ADDR_OUTSET:   out_d  = out_q | wd;
            ADDR_OUTCLEAR: out_d  = out_q & ~wd;
            default:       ;
         endcase
      end
      // OR-ing the new edges in last lets a same-cycle edge override write-1-to-clear.
      cap_d = cap_d | edge_det;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q  <= RESET_OUT[WIDTH-1:0];
         dir_q  <= RESET_DIR[WIDTH-1:0];
         mask_q <= '0;
         cap_q  <= '0;
      end else begin
         out_q  <= out_d;
         dir_q  <= dir_d;
         mask_q <= mask_d;
         cap_q  <= cap_d;
      end
   end

   always_comb begin
      case (address)
         ADDR_DATA:    rd_val = sync_in;
         ADDR_DIR:     rd_val = dir_q;
         ADDR_MASK:    rd_val = mask_q;
         ADDR_CAPTURE: rd_val = cap_q;
         default:      rd_val = '0;
      endcase
      readdata              = '0;
      readdata[WIDTH-1:0]   = rd_val;
   end

   assign out_port = out_q;
   assign oe_port  = dir_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Bench for avalon_pio_gen: an 8-bit rising-edge instance and a 32-bit any-edge instance
// sharing one Avalon bus, with a table of register vectors and hand-timed edge sequences.
module tb_avalon_pio_gen;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect_a, chipselect_b;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata_a, readdata_b;
   logic [7:0]  in_port_a, out_port_a, oe_port_a;
   logic [31:0] in_port_b, out_port_b, oe_port_b;
   logic        irq_a, irq_b;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [7:0]  exp_out;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[11];

   always #5 clk = ~clk;

   avalon_pio_gen #(
      .WIDTH(8), .RESET_OUT(32'hA5), .RESET_DIR(32'h0), .EDGE_TYPE(0), .SYNC_STAGES(2)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect_a),
      .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
      .in_port(in_port_a), .out_port(out_port_a), .oe_port(oe_port_a), .irq(irq_a)
   );

   avalon_pio_gen #(
      .WIDTH(32), .RESET_OUT(32'h0), .RESET_DIR(32'h0), .EDGE_TYPE(2), .SYNC_STAGES(2)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect_b),
      .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
      .in_port(in_port_b), .out_port(out_port_b), .oe_port(oe_port_b), .irq(irq_b)
   );

   task automatic check(string name, logic [31:0] act);
      logic [31:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s: no expected value queued, got %h", name, act);
         return;
      end
      e = exp_q.pop_front();
      if (act !== e) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, e);
      end
   endtask

   task automatic expect_val(string name, logic [31:0] act, logic [31:0] e);
      exp_q.push_back(e);
      check(name, act);
   endtask

   task automatic rd(bit sel, logic [2:0] a, logic [31:0] e, string name);
      address = a;
      exp_q.push_back(e);
      #1;
      check(name, sel ? readdata_b : readdata_a);
   endtask

   task automatic wr(bit sel, logic [2:0] a, logic [31:0] d);
      address      = a;
      writedata    = d;
      write_n      = 1'b0;
      chipselect_a = !sel;
      chipselect_b = sel;
      @(negedge clk);
      write_n      = 1'b1;
      chipselect_a = 1'b0;
      chipselect_b = 1'b0;
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0]  m;
      logic [7:0]  d;
      logic [31:0] v;
      int          op;

      reset_n      = 1'b0;
      address      = '0;
      chipselect_a = 1'b0;
      chipselect_b = 1'b0;
      write_n      = 1'b1;
      writedata    = '0;
      in_port_a    = '0;
      in_port_b    = '0;

      tbl[0]  = '{3'd0, 32'h0000_000F, 8'h0F, 32'h0};
      tbl[1]  = '{3'd4, 32'h0000_0030, 8'h3F, 32'h0};
      tbl[2]  = '{3'd5, 32'h0000_0003, 8'h3C, 32'h0};
      tbl[3]  = '{3'd1, 32'h0000_00A5, 8'h3C, 32'hA5};
      tbl[4]  = '{3'd1, 32'h0000_01FF, 8'h3C, 32'hFF};
      tbl[5]  = '{3'd2, 32'h0000_005A, 8'h3C, 32'h5A};
      tbl[6]  = '{3'd2, 32'h0000_0000, 8'h3C, 32'h0};
      tbl[7]  = '{3'd6, 32'hFFFF_FFFF, 8'h3C, 32'h0};
      tbl[8]  = '{3'd7, 32'hFFFF_FFFF, 8'h3C, 32'h0};
      tbl[9]  = '{3'd0, 32'hFFFF_FF3C, 8'h3C, 32'h0};
      tbl[10] = '{3'd1, 32'h0000_0000, 8'h3C, 32'h0};

      // Reset values while reset_n is held low.
      tick(2);
      expect_val("rst_out_a", {24'h0, out_port_a}, 32'hA5);
      expect_val("rst_oe_a", {24'h0, oe_port_a}, 32'h0);
      expect_val("rst_irq_a", {31'h0, irq_a}, 32'h0);
      expect_val("rst_out_b", out_port_b, 32'h0);
      expect_val("rst_irq_b", {31'h0, irq_b}, 32'h0);
      reset_n = 1'b1;
      tick(1);
      rd(0, 3'd0, 32'h0, "rst_data_a");
      rd(1, 3'd0, 32'h0, "rst_data_b");

      // Register map vectors on the 8-bit instance.
      tick(1);
      for (int i = 0; i < 11; i++) begin
         wr(0, tbl[i].addr, tbl[i].wdata);
         rd(0, tbl[i].addr, tbl[i].exp_rd, $sformatf("vec%0d_rd", i));
         expect_val($sformatf("vec%0d_out", i), {24'h0, out_port_a}, {24'h0, tbl[i].exp_out});
      end

      // Rising-edge capture latency, no capture on fall, write-1-to-clear.
      tick(1);
      in_port_a[2] = 1'b1;
      tick(2);
      rd(0, 3'd3, 32'h0, "cap_early");
      rd(0, 3'd0, 32'h04, "data_latency");
      tick(1);
      rd(0, 3'd3, 32'h04, "cap_rise");
      in_port_a[2] = 1'b0;
      tick(4);
      rd(0, 3'd3, 32'h04, "cap_no_fall");
      wr(0, 3'd3, 32'h04);
      rd(0, 3'd3, 32'h0, "cap_w1c");

      // Interrupt masking.
      tick(1);
      in_port_a[5] = 1'b1;
      tick(3);
      rd(0, 3'd3, 32'h20, "cap_b5");
      expect_val("irq_masked", {31'h0, irq_a}, 32'h0);
      wr(0, 3'd2, 32'h20);
      expect_val("irq_unmask", {31'h0, irq_a}, 32'h1);
      wr(0, 3'd3, 32'h20);
      expect_val("irq_cleared", {31'h0, irq_a}, 32'h0);

      // Clear landing in the same cycle as a new bit-1 edge: the set wins.
      wr(0, 3'd2, 32'h22);
      tick(1);
      in_port_a[1] = 1'b1;
      tick(3);
      expect_val("irq_b1", {31'h0, irq_a}, 32'h1);
      in_port_a[1] = 1'b0;
      tick(4);
      rd(0, 3'd3, 32'h02, "cap_b1_hold");
      in_port_a[1] = 1'b1;
      tick(2);
      wr(0, 3'd3, 32'h02);
      rd(0, 3'd3, 32'h02, "collide_cap");
      expect_val("collide_irq", {31'h0, irq_a}, 32'h1);
      wr(0, 3'd3, 32'h02);
      rd(0, 3'd3, 32'h0, "collide_clr");
      expect_val("collide_irq_off", {31'h0, irq_a}, 32'h0);

      // Random set/clear/data writes against a reference register.
      m = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         op = $urandom_range(0, 2);
         d  = 8'($urandom_range(0, 255));
         case (op)
            0:       begin m = d;      wr(0, 3'd0, {24'h0, d}); end
            1:       begin m = m | d;  wr(0, 3'd4, {24'h0, d}); end
            default: begin m = m & ~d; wr(0, 3'd5, {24'h0, d}); end
         endcase
         expect_val($sformatf("rand%0d_out", i), {24'h0, out_port_a}, {24'h0, m});
      end

      // 32-bit any-edge instance.
      tick(1);
      in_port_b[31] = 1'b1;
      tick(2);
      rd(1, 3'd3, 32'h0, "b_cap_early");
      tick(1);
      rd(1, 3'd3, 32'h8000_0000, "b_cap_rise");
      wr(1, 3'd3, 32'h8000_0000);
      rd(1, 3'd3, 32'h0, "b_cap_clr");
      in_port_b[31] = 1'b0;
      tick(3);
      rd(1, 3'd3, 32'h8000_0000, "b_cap_fall");
      expect_val("b_irq_masked", {31'h0, irq_b}, 32'h0);
      wr(1, 3'd1, 32'hFFFF_0000);
      expect_val("b_oe", oe_port_b, 32'hFFFF_0000);
      rd(1, 3'd1, 32'hFFFF_0000, "b_dir_rd");
      v = $urandom;
      in_port_b = v;
      tick(2);
      rd(1, 3'd0, v, "b_data_rand");

      // Asynchronous reset in the middle of a cycle.
      tick(1);
      in_port_a[7] = 1'b1;
      tick(3);
      rd(0, 3'd3, 32'h80, "pre_rst_cap");
      tick(1);
      #2;
      reset_n = 1'b0;
      #1;
      expect_val("arst_out", {24'h0, out_port_a}, 32'hA5);
      expect_val("arst_oe_b", oe_port_b, 32'h0);
      rd(0, 3'd3, 32'h0, "arst_cap");
      tick(1);
      reset_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
